stopwatch_ctrl: RTL and testbench

- Controller that sequences a cascade of decimal (0–9) BCD digit counters as a start/stop/lap/clear stopwatch.
- Owns the run FSM, a clock prescaler that produces count ticks, the inter-digit carry chain, lap-freeze of the display, and overflow flagging.
- Sits between debounced single-cycle button pulses and the 7-segment display driver.

---
 rtl/stopwatch_pkg.sv | 14 +
 rtl/bcd_digit.sv | 29 ++
 rtl/stopwatch_ctrl.sv | 125 ++++++++++++
 tb/tb_stopwatch_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared state encoding and BCD constants for the stopwatch
package stopwatch_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_LAP   = 2'd3
    } state_e;

    localparam int             BCD_W   = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one decimal digit of the cascaded counter with carry out
module bcd_digit
    import stopwatch_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [BCD_W-1:0] q,
    output logic             co
);

    logic [BCD_W-1:0] q_q;

    // Count 0..9, wrapping to 0; clear has priority over counting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else if (clr) begin
            q_q <= '0;
        end else if (en) begin
            q_q <= (q_q == BCD_MAX) ? '0 : q_q + 1'b1;
        end
    end

    assign q  = q_q;
    assign co = en && (q_q == BCD_MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - start/stop/lap/clear stopwatch over cascaded BCD digits
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DIV  = 4,
    parameter int NDIG = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_stop_pls,
    input  logic                  lap_pls,
    input  logic                  clr_pls,
    output logic [BCD_W*NDIG-1:0] disp_bcd,
    output logic                  run,
    output logic                  frozen,
    output logic                  tick,
    output logic                  ovf
);

    localparam int             PW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

    state_e                  state_q;
    logic                    run_q;
    logic                    frozen_q;
    logic                    ovf_q;
    logic [PW-1:0]           presc_q;
    logic [BCD_W*NDIG-1:0]   snap_q;
    logic [BCD_W*NDIG-1:0]   live;
    logic [NDIG:0]           carry;
    logic                    counting;
    logic                    clr_cnt;

    assign counting = (state_q == S_RUN) || (state_q == S_LAP);
    assign tick     = counting && (presc_q == PRESC_MAX);
    // The only way back to IDLE (besides reset) is clear from PAUSE
    assign clr_cnt  = (state_q == S_PAUSE) && clr_pls;
    assign carry[0] = tick;

    genvar gi;
    generate
        for (gi = 0; gi < NDIG; gi++) begin : g_dig
            bcd_digit u_dig (
                .clk   (clk),
                .rst_n (rst_n),
                .clr   (clr_cnt),
                .en    (carry[gi]),
                .q     (live[gi*BCD_W +: BCD_W]),
                .co    (carry[gi+1])
            );
        end
    endgenerate

    // Prescaler: advances while counting, holds in PAUSE, zeroed on clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else if (clr_cnt) begin
            presc_q <= '0;
        end else if (counting) begin
            presc_q <= tick ? '0 : presc_q + PW'(1);
        end
    end

    // Run FSM with registered run/frozen flags, lap snapshot and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            run_q    <= 1'b0;
            frozen_q <= 1'b0;
            ovf_q    <= 1'b0;
            snap_q   <= '0;
        end else begin
            if (carry[NDIG]) begin
                ovf_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (start_stop_pls) begin
                        state_q <= S_RUN;
                        run_q   <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (start_stop_pls) begin
                        state_q <= S_PAUSE;
                        run_q   <= 1'b0;
                    end else if (lap_pls) begin
                        state_q  <= S_LAP;
                        frozen_q <= 1'b1;
                        snap_q   <= live;
                    end
                end
                S_LAP: begin
                    if (start_stop_pls) begin
                        state_q  <= S_PAUSE;
                        run_q    <= 1'b0;
                        frozen_q <= 1'b0;
                    end else if (lap_pls) begin
                        state_q  <= S_RUN;
                        frozen_q <= 1'b0;
                    end
                end
                S_PAUSE: begin
                    if (clr_pls) begin
                        state_q <= S_IDLE;
                        ovf_q   <= 1'b0;
                    end else if (start_stop_pls) begin
                        state_q <= S_RUN;
                        run_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign disp_bcd = frozen_q ? snap_q : live;
    assign run      = run_q;
    assign frozen   = frozen_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - scoreboard bench for stopwatch_ctrl at DIV=2 and DIV=1
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ss, lap, clr;
    logic [7:0] disp0, disp1;
    logic       run0, frozen0, tick0, ovf0;
    logic       run1, frozen1, tick1, ovf1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    stopwatch_ctrl #(.DIV(2), .NDIG(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .start_stop_pls(ss), .lap_pls(lap), .clr_pls(clr),
        .disp_bcd(disp0), .run(run0), .frozen(frozen0), .tick(tick0), .ovf(ovf0)
    );

    stopwatch_ctrl #(.DIV(1), .NDIG(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .start_stop_pls(ss), .lap_pls(lap), .clr_pls(clr),
        .disp_bcd(disp1), .run(run1), .frozen(frozen1), .tick(tick1), .ovf(ovf1)
    );

    // Reference model: modes 0 idle, 1 run, 2 pause, 3 lap; count is a plain integer 0..99
    int m_div[2] = '{2, 1};
    int m_mode[2];
    int m_count[2];
    int m_phase[2];
    int m_lapv[2];
    int m_ovf[2];

    logic [11:0] exp_q0[$];
    logic [11:0] exp_q1[$];

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) % 10) * 16 + (v % 10));
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_mode[d] = 0; m_count[d] = 0; m_phase[d] = 0; m_lapv[d] = 0; m_ovf[d] = 0;
        end
    endtask

    function automatic logic [11:0] expected(input int d);
        logic running, t;
        running = (m_mode[d] == 1) || (m_mode[d] == 3);
        t = running && (m_phase[d] == m_div[d] - 1);
        return {(m_mode[d] == 3) ? to_bcd(m_lapv[d]) : to_bcd(m_count[d]),
                running, (m_mode[d] == 3), t, (m_ovf[d] != 0)};
    endfunction

    task automatic model_step(input bit s, input bit l, input bit c);
        for (int d = 0; d < 2; d++) begin
            int old_count;
            bit running, t;
            old_count = m_count[d];
            running = (m_mode[d] == 1) || (m_mode[d] == 3);
            t = running && (m_phase[d] == m_div[d] - 1);
            if (t) begin
                if (m_count[d] == 99) begin
                    m_count[d] = 0;
                    m_ovf[d] = 1;
                end else begin
                    m_count[d] = m_count[d] + 1;
                end
            end
            if (running) m_phase[d] = (m_phase[d] + 1) % m_div[d];
            case (m_mode[d])
                0: if (s) m_mode[d] = 1;
                1: if (s) m_mode[d] = 2;
                   else if (l) begin m_mode[d] = 3; m_lapv[d] = old_count; end
                3: if (s) m_mode[d] = 2;
                   else if (l) m_mode[d] = 1;
                default: if (c) begin
                             m_mode[d] = 0; m_count[d] = 0; m_phase[d] = 0; m_ovf[d] = 0;
                         end else if (s) m_mode[d] = 1;
            endcase
        end
    endtask

    // One clock cycle: drive pulses, queue expectations, advance the model at the edge
    task automatic cycle(input bit s, input bit l, input bit c);
        ss = s; lap = l; clr = c;
        exp_q0.push_back(expected(0));
        exp_q1.push_back(expected(1));
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step(s, l, c);
        #1;
    endtask

    // Monitor: pop and compare whenever an expectation is outstanding
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q0.size() > 0) begin
                logic [11:0] e, g;
                e = exp_q0.pop_front();
                g = {disp0, run0, frozen0, tick0, ovf0};
                checks++;
                if (g !== e) begin
                    failures++;
                    $display("FAIL sb_div2 t=%0t got disp=%h run=%b frz=%b tick=%b ovf=%b exp disp=%h run=%b frz=%b tick=%b ovf=%b",
                             $time, g[11:4], g[3], g[2], g[1], g[0], e[11:4], e[3], e[2], e[1], e[0]);
                end
            end
            if (exp_q1.size() > 0) begin
                logic [11:0] e, g;
                e = exp_q1.pop_front();
                g = {disp1, run1, frozen1, tick1, ovf1};
                checks++;
                if (g !== e) begin
                    failures++;
                    $display("FAIL sb_div1 t=%0t got disp=%h run=%b frz=%b tick=%b ovf=%b exp disp=%h run=%b frz=%b tick=%b ovf=%b",
                             $time, g[11:4], g[3], g[2], g[1], g[0], e[11:4], e[3], e[2], e[1], e[0]);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; ss = 1'b0; lap = 1'b0; clr = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        repeat (3) cycle(0, 0, 0);
        rst_n = 1'b1;

        // IDLE ignores lap and clear
        cycle(0, 1, 1);
        cycle(0, 1, 0);
        // Start and count long enough for both instances to overflow
        cycle(1, 0, 0);
        repeat (420) cycle(0, 0, 0);
        // Clear in RUN is ignored; lap freeze and release
        cycle(0, 0, 1);
        cycle(0, 1, 0);
        repeat (11) cycle(0, 0, 0);
        cycle(0, 1, 0);
        repeat (3) cycle(0, 0, 0);
        // LAP straight to PAUSE, long hold, lap ignored in PAUSE
        cycle(0, 1, 0);
        cycle(1, 0, 0);
        repeat (20) cycle(0, 0, 0);
        cycle(0, 1, 0);
        cycle(1, 0, 0);
        repeat (5) cycle(0, 0, 0);
        cycle(1, 0, 0);
        // Clear and start together in PAUSE: clear wins
        cycle(1, 0, 1);
        repeat (3) cycle(0, 0, 0);

        // Randomized pulse traffic
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom_range(0, 11) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 5) == 0));
        end

        // Bring to a known running state, then reset asynchronously at count 45
        if (m_mode[0] == 1 || m_mode[0] == 3) cycle(1, 0, 0);
        cycle(0, 0, 1);
        cycle(1, 0, 0);
        for (int i = 0; i < 300 && !(m_count[0] == 45 && m_mode[0] == 1); i++) cycle(0, 0, 0);
        checks++;
        if (!(m_count[0] == 45 && m_mode[0] == 1)) begin
            failures++;
            $display("FAIL reach_45 got model count=%0d mode=%0d exp count=45 mode=1", m_count[0], m_mode[0]);
        end
        cycle(0, 0, 0);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({disp0, run0, frozen0, tick0, ovf0, disp1, run1, frozen1, tick1, ovf1} !== 24'h0) begin
            failures++;
            $display("FAIL async_reset got disp0=%h run0=%b tick0=%b ovf0=%b disp1=%h run1=%b tick1=%b ovf1=%b exp all zero",
                     disp0, run0, tick0, ovf0, disp1, run1, tick1, ovf1);
        end
        model_reset();
        repeat (2) cycle(0, 0, 0);
        rst_n = 1'b1;
        cycle(1, 0, 0);
        repeat (6) cycle(0, 0, 0);

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            failures++;
            $display("FAIL drain got pending=%0d/%0d exp 0/0", exp_q0.size(), exp_q1.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
